// File: rtl/shift_seq_unit.sv
// ============================================================================
// Module   : shift_seq_unit
// Purpose  : Multi-cycle shifter, one bit per clock (LSL/LSR/ASR/ROR) with
//            valid/ready request and result handshakes.
// Options  : SHIFT_ROTATE_EN - when defined, op 2'b11 is rotate right;
//            otherwise op 2'b11 behaves as LSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_unit #(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic             in_fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  localparam logic [1:0] c_OP_LSL = 2'b00;
  localparam logic [1:0] c_OP_ASR = 2'b10;
`ifdef SHIFT_ROTATE_EN
  localparam logic [1:0] c_OP_ROR = 2'b11;
`endif
  localparam logic [AMT_W-1:0] c_AMT_MAX = AMT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_fill;
  logic             r_carry;

  logic [AMT_W-1:0] w_amt_sat;
  logic [WIDTH-1:0] w_next_data;
  logic             w_next_carry;

  assign w_amt_sat = (in_amt > c_AMT_MAX) ? c_AMT_MAX : in_amt;
  assign out_data  = r_data;
  assign out_carry = r_carry;

  // Single-position step; saturated amounts fall out of repeating it WIDTH times.
  always_comb begin
    w_next_data  = {r_fill, r_data[WIDTH-1:1]};
    w_next_carry = r_data[0];
    case (r_op)
      c_OP_LSL: begin
        w_next_data  = {r_data[WIDTH-2:0], r_fill};
        w_next_carry = r_data[WIDTH-1];
      end
      c_OP_ASR: begin
        w_next_data  = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_next_carry = r_data[0];
      end
`ifdef SHIFT_ROTATE_EN
      c_OP_ROR: begin
        w_next_data  = {r_data[0], r_data[WIDTH-1:1]};
        w_next_carry = r_data[0];
      end
`endif
      default: begin
        w_next_data  = {r_fill, r_data[WIDTH-1:1]};
        w_next_carry = r_data[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_cnt     <= '0;
      r_op      <= 2'b00;
      r_fill    <= 1'b0;
      r_carry   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data   <= in_data;
            r_op     <= in_op;
            r_fill   <= in_fill;
            r_cnt    <= w_amt_sat;
            r_carry  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (w_amt_sat == '0) begin
              r_state   <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data  <= w_next_data;
          r_carry <= w_next_carry;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == AMT_W'(1)) begin
            r_state   <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // in_ready rises only after the accept edge, so no request overlaps.
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
// ============================================================================
// Module   : tb_shift_seq_unit
// Purpose  : Directed self-checking bench for shift_seq_unit (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_unit;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_op;
  logic             in_fill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'd0);
    chk({tag, ".out_carry"}, 32'(out_carry), 32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  // Issue one request, measure latency, optionally stall in DONE, then accept.
  task automatic run(input string tag, input logic [7:0] d, input logic [3:0] a,
                     input logic [1:0] op, input logic f, input logic [7:0] ed,
                     input logic ec, input int n, input int stall);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op; in_fill = f;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    chk({tag, ".latency"}, 32'(cyc), 32'(n + 1));
    chk({tag, ".data"},    32'(out_data),  32'(ed));
    chk({tag, ".carry"},   32'(out_carry), 32'(ec));
    chk({tag, ".busy"},    32'(busy),      32'd1);
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_data = 8'h3C; in_amt = 4'd1; in_op = 2'b00;
      @(negedge clk);
      chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".stall_data"},  32'(out_data),  32'(ed));
      chk({tag, ".stall_carry"}, 32'(out_carry), 32'(ec));
      chk({tag, ".stall_ready"}, 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".in_ready_after"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = 2'b00;
    in_fill = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    run("lsl4",      8'h96, 4'd4,  2'b00, 1'b0, 8'h60, 1'b1, 4, 0);
    run("asr2",      8'h96, 4'd2,  2'b10, 1'b0, 8'hE5, 1'b1, 2, 0);
    run("lsr2",      8'h96, 4'd2,  2'b01, 1'b0, 8'h25, 1'b1, 2, 0);
    run("amt0",      8'h96, 4'd0,  2'b00, 1'b1, 8'h96, 1'b0, 0, 0);
    run("asr_sat",   8'h96, 4'd15, 2'b10, 1'b0, 8'hFF, 1'b1, 8, 0);
    run("lsl8_f1",   8'h96, 4'd8,  2'b00, 1'b1, 8'hFF, 1'b0, 8, 0);
    run("lsr_f1",    8'h96, 4'd3,  2'b01, 1'b1, 8'hF2, 1'b1, 3, 0);
`ifdef SHIFT_ROTATE_EN
    run("ror3",      8'h96, 4'd3,  2'b11, 1'b0, 8'hD2, 1'b1, 3, 0);
    run("ror_sat",   8'h96, 4'd12, 2'b11, 1'b1, 8'h96, 1'b1, 8, 0);
`else
    run("op11_lsr3", 8'h96, 4'd3,  2'b11, 1'b0, 8'h12, 1'b1, 3, 0);
    run("op11_f1",   8'h96, 4'd3,  2'b11, 1'b1, 8'hF2, 1'b1, 3, 0);
`endif
    run("stall",     8'h96, 4'd4,  2'b00, 1'b0, 8'h60, 1'b1, 4, 10);

    // Asynchronous abort three shifts into a six-shift LSL.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h96; in_amt = 4'd6; in_op = 2'b00; in_fill = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 8'h96, 4'd2, 2'b01, 1'b0, 8'h25, 1'b1, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
